// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC/counter types, FSM state encoding and the
// saturating counter helper used by the fetch sequencer.
package fetch_pkg;

    localparam int PC_W      = 12;
    localparam int LUT_AW    = 5;
    localparam int CNT_W     = 16;
    localparam int LUT_DEPTH = 32;

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam pc_t START_ADDR = 12'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        cnt_t r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle of the launch handshake, decoder flags, LUT write
// port and the sequencer outputs.
//   master : drives start, pc_cur, decoder flags, LUT writes; sees outputs
//   slave  : the sequencer itself (fetch_ctrl)
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic              start;
    pc_t               pc_cur;
    logic              branch_taken;
    logic [LUT_AW-1:0] branch_idx;
    logic              halt_insn;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    pc_t               lut_wdata;
    pc_t               pc_next;
    logic              running;
    logic              done;
    cnt_t              cycle_count;

    modport master (
        output start, pc_cur, branch_taken, branch_idx, halt_insn,
               lut_we, lut_waddr, lut_wdata,
        input  pc_next, running, done, cycle_count
    );

    modport slave (
        input  start, pc_cur, branch_taken, branch_idx, halt_insn,
               lut_we, lut_waddr, lut_wdata,
        output pc_next, running, done, cycle_count
    );

endinterface

// File: rtl/branch_lut.sv
// branch_lut: 32 x PC_W branch-target register file.
//   clk, reset     : clock, synchronous active-high clear of every entry
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational read port (a same-cycle write to the
//                    read index is visible only after the edge)
module branch_lut
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  pc_t               wdata,
    input  logic [LUT_AW-1:0] raddr,
    output pc_t               rdata
);

    pc_t mem_q [LUT_DEPTH];
    pc_t mem_d [LUT_DEPTH];

    // Next-state of the table: copy, then overlay the single write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[waddr] = mem_q[waddr];
        end
    end

    // Table storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= 12'd0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program lifecycle sequencer feeding the PC register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_ctrl_if.slave -- start handshake, current PC,
//                decoder branch/halt flags, LUT write port, and the
//                pc_next / running / done / cycle_count outputs
// pc_next is combinational; running, done and cycle_count are registered.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    fetch_state_t state_q, state_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    cnt_t         cnt_q, cnt_d;
    pc_t          lut_rdata_s;
    pc_t          pc_next_s;

    branch_lut u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (bus.branch_idx),
        .rdata (lut_rdata_s)
    );

    // Next-state, done flag and cycle counter.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        running_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARMED;
                    done_d  = 1'b0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                // Launch happens when start is released.
                if (bus.start) begin
                    state_d = ARMED;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The halt cycle itself is still counted.
                cnt_d = sat_inc(cnt_q);
                if (bus.halt_insn) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (bus.start) begin
                    state_d = ARMED;
                    done_d  = 1'b0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                cnt_d   = 16'd0;
            end
        endcase
        // running mirrors the state being entered so it lines up with it.
        running_d = (state_d == RUN);
    end

    // Next-PC select; halt has priority over a taken branch.
    always_comb begin
        pc_next_s = START_ADDR;
        case (state_q)
            IDLE, ARMED: begin
                pc_next_s = START_ADDR;
            end
            RUN: begin
                if (bus.halt_insn) begin
                    pc_next_s = bus.pc_cur;
                end else if (bus.branch_taken) begin
                    pc_next_s = lut_rdata_s;
                end else begin
                    pc_next_s = bus.pc_cur + 12'd1;
                end
            end
            HALTED: begin
                pc_next_s = bus.pc_cur;
            end
            default: begin
                pc_next_s = START_ADDR;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_next     = pc_next_s;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A PC register is modelled
// in the bench (pc_next fed back into pc_cur) and can be bypassed to force
// pc_cur. Expected values come from a lifecycle model built on flags, an
// integer counter and an integer target table.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit fb;

    // Reference model
    bit m_run, m_armed, m_done;
    int m_count;
    int m_lut [32];

    function automatic pc_t exp_pc();
        int v;
        if (m_run) begin
            if (bus.halt_insn)         v = int'(bus.pc_cur);
            else if (bus.branch_taken) v = m_lut[bus.branch_idx];
            else                       v = (int'(bus.pc_cur) + 1) % 4096;
        end else if (m_done) begin
            v = int'(bus.pc_cur);
        end else begin
            v = 0;
        end
        return pc_t'(v);
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_run = 1'b0; m_armed = 1'b0; m_done = 1'b0; m_count = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        if (m_armed) begin
            if (!bus.start) begin m_armed = 1'b0; m_run = 1'b1; end
        end else if (m_run) begin
            if (m_count < 65535) m_count++;
            if (bus.halt_insn) begin m_run = 1'b0; m_done = 1'b1; end
        end else if (bus.start) begin
            m_armed = 1'b1; m_done = 1'b0; m_count = 0;
        end
        if (bus.lut_we) m_lut[bus.lut_waddr] = int'(bus.lut_wdata);
    endfunction

    task automatic tick();
        pc_t nxt;
        #1;
        nxt = bus.pc_next;
        model_edge();
        @(posedge clk);
        #1;
        if (fb) bus.pc_cur = rst ? START_ADDR : nxt;
    endtask

    task automatic launch(input int hold);
        bus.start = 1'b1;
        repeat (hold) tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        #1;
        n_checks++; if (bus.pc_next !== 12'h000) begin n_fail++; $display("FAIL reset_pc_next got %0h want 0", bus.pc_next); end
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b want 0", bus.running); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        n_checks++; if (bus.cycle_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %0h want 0", bus.cycle_count); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        int n;
        launch(2);
        n = int'($urandom_range(10, 20));
        for (int i = 0; i < n; i++) begin
            #1;
            n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL seq_running cyc %0d got %0b want 1", i, bus.running); end
            n_checks++; if (bus.pc_next !== pc_t'(i + 1)) begin n_fail++; $display("FAIL seq_pc cyc %0d got %0h want %0h", i, bus.pc_next, i + 1); end
            n_checks++; if (bus.cycle_count !== 16'(i)) begin n_fail++; $display("FAIL seq_count cyc %0d got %0d want %0d", i, bus.cycle_count, i); end
            tick();
        end
        bus.halt_insn = 1'b1;
        tick();
        bus.halt_insn = 1'b0;
    endtask

    task automatic test_branch();
        int guard;
        bus.lut_we = 1'b1; bus.lut_waddr = 5'd3; bus.lut_wdata = 12'h0A0;
        tick();
        bus.lut_we = 1'b0;
        launch(1);
        guard = 0;
        while (bus.pc_cur !== 12'd5 && guard < 20) begin tick(); guard++; end
        n_checks++; if (bus.pc_cur !== 12'd5) begin n_fail++; $display("FAIL branch_reach_pc5 got %0h want 5", bus.pc_cur); end
        bus.branch_taken = 1'b1; bus.branch_idx = 5'd3;
        #1;
        n_checks++; if (bus.pc_next !== 12'h0A0) begin n_fail++; $display("FAIL branch_target got %0h want 0a0", bus.pc_next); end
        tick();
        bus.branch_taken = 1'b0; bus.branch_idx = 5'(($urandom));
        #1;
        n_checks++; if (bus.pc_next !== 12'h0A1) begin n_fail++; $display("FAIL branch_follow got %0h want 0a1", bus.pc_next); end
    endtask

    task automatic test_halt();
        fb = 1'b0;
        bus.pc_cur = 12'd7;
        bus.halt_insn = 1'b1; bus.branch_taken = 1'b1; bus.branch_idx = 5'd3;
        #1;
        n_checks++; if (bus.pc_next !== 12'd7) begin n_fail++; $display("FAIL halt_pc got %0h want 7", bus.pc_next); end
        tick();
        bus.halt_insn = 1'b0; bus.branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL halt_done cyc %0d got %0b want 1", i, bus.done); end
            n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL halt_running cyc %0d got %0b want 0", i, bus.running); end
            n_checks++; if (bus.cycle_count !== 16'(m_count)) begin n_fail++; $display("FAIL halt_count cyc %0d got %0d want %0d", i, bus.cycle_count, m_count); end
            n_checks++; if (bus.pc_next !== 12'd7) begin n_fail++; $display("FAIL halt_hold_pc cyc %0d got %0h want 7", i, bus.pc_next); end
            tick();
        end
        fb = 1'b1;
    endtask

    task automatic test_restart();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %0b want 0", bus.done); end
        n_checks++; if (bus.cycle_count !== 16'd0) begin n_fail++; $display("FAIL restart_count got %0d want 0", bus.cycle_count); end
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL restart_armed_running got %0b want 0", bus.running); end
        n_checks++; if (bus.pc_next !== START_ADDR) begin n_fail++; $display("FAIL restart_armed_pc got %0h want 0", bus.pc_next); end
        tick();
        #1;
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL restart_running got %0b want 1", bus.running); end
        n_checks++; if (bus.pc_next !== 12'd1) begin n_fail++; $display("FAIL restart_first_pc got %0h want 1", bus.pc_next); end
    endtask

    task automatic test_wrap_saturate();
        fb = 1'b0;
        bus.pc_cur = 12'hFFF;
        #1;
        n_checks++; if (bus.pc_next !== 12'h000) begin n_fail++; $display("FAIL wrap_pc got %0h want 0", bus.pc_next); end
        repeat (65540) tick();
        #1;
        n_checks++; if (bus.cycle_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count got %0h want ffff", bus.cycle_count); end
        n_checks++; if (bus.cycle_count !== 16'(m_count)) begin n_fail++; $display("FAIL sat_model got %0h want %0h", bus.cycle_count, m_count); end
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL sat_running got %0b want 1", bus.running); end
        fb = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.start        = ($urandom_range(0, 7) == 0);
            bus.halt_insn    = ($urandom_range(0, 15) == 0);
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.branch_idx   = 5'($urandom);
            bus.lut_we       = ($urandom_range(0, 3) == 0);
            bus.lut_waddr    = 5'($urandom);
            bus.lut_wdata    = 12'($urandom);
            #1;
            n_checks++; if (bus.pc_next !== exp_pc()) begin n_fail++; $display("FAIL rand_pc cyc %0d got %0h want %0h", i, bus.pc_next, exp_pc()); end
            tick();
            n_checks++; if (bus.running !== m_run) begin n_fail++; $display("FAIL rand_running cyc %0d got %0b want %0b", i, bus.running, m_run); end
            n_checks++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rand_done cyc %0d got %0b want %0b", i, bus.done, m_done); end
            n_checks++; if (bus.cycle_count !== 16'(m_count)) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, bus.cycle_count, m_count); end
        end
        bus.start = 1'b0; bus.halt_insn = 1'b0; bus.branch_taken = 1'b0; bus.lut_we = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bus.lut_we = 1'b1; bus.lut_waddr = 5'd3; bus.lut_wdata = 12'h800 | 12'($urandom_range(1, 2047));
        tick();
        bus.lut_waddr = 5'd9; bus.lut_wdata = 12'h123;
        tick();
        bus.lut_we = 1'b0;
        launch(1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL midrst_running got %0b want 0", bus.running); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %0b want 0", bus.done); end
        n_checks++; if (bus.cycle_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", bus.cycle_count); end
        n_checks++; if (bus.pc_next !== START_ADDR) begin n_fail++; $display("FAIL midrst_pc got %0h want 0", bus.pc_next); end
        launch(1);
        bus.branch_taken = 1'b1; bus.branch_idx = 5'd3;
        #1;
        n_checks++; if (bus.pc_next !== 12'h000) begin n_fail++; $display("FAIL midrst_lut3 got %0h want 0", bus.pc_next); end
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fb = 1'b1;
        bus.start = 1'b0; bus.pc_cur = START_ADDR;
        bus.branch_taken = 1'b0; bus.branch_idx = 5'd0; bus.halt_insn = 1'b0;
        bus.lut_we = 1'b0; bus.lut_waddr = 5'd0; bus.lut_wdata = 12'd0;
        m_run = 1'b0; m_armed = 1'b0; m_done = 1'b0; m_count = 0;
        foreach (m_lut[i]) m_lut[i] = 0;

        test_reset();
        test_sequential();
        test_branch();
        test_halt();
        test_restart();
        test_wrap_saturate();
        test_random();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
